// File: rtl/fp_minmax_reduce_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared widths, ordering codes, FSM states and NaN helper for
//               the streaming floating-point min/max reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int EXP_WIDTH_DEF = 8;
    localparam int MAN_WIDTH_DEF = 23;
    localparam int IDX_WIDTH_DEF = 8;

    // Three-way ordering codes produced by the comparator
    localparam logic [1:0] ORD_GT = 2'b01;
    localparam logic [1:0] ORD_EQ = 2'b00;
    localparam logic [1:0] ORD_LT = 2'b11;

    // Canonical quiet NaN reported as both extremes when a stream carries only NaNs
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // NaN: exponent all ones with a non-zero mantissa
    function automatic logic is_nan(input logic [EXP_WIDTH_DEF-1:0] exp_f,
                                    input logic [MAN_WIDTH_DEF-1:0] man_f);
        return (&exp_f) && (|man_f);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_minmax_reduce_if.sv
// ============================================================================
// Module      : fp_minmax_reduce_if
// Description : Operand stream and result handshake bundle for the min/max
//               reduction stage. out_nan exists only with FP_MINMAX_NAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_minmax_reduce_if #(
    parameter int WIDTH     = fp_pkg::WIDTH_DEF,
    parameter int IDX_WIDTH = fp_pkg::IDX_WIDTH_DEF
);
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_min;
    logic [WIDTH-1:0]     out_max;
    logic [IDX_WIDTH-1:0] out_min_idx;
    logic [IDX_WIDTH-1:0] out_max_idx;
    logic [IDX_WIDTH:0]   out_count;
    logic                 out_ovf;

`ifdef FP_MINMAX_NAN_EN
    logic                 out_nan;

    modport master (output mode, in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_min, out_max, out_min_idx,
                           out_max_idx, out_count, out_ovf, out_nan);
    modport slave  (input  mode, in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_min, out_max, out_min_idx,
                           out_max_idx, out_count, out_ovf, out_nan);
`else
    modport master (output mode, in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_min, out_max, out_min_idx,
                           out_max_idx, out_count, out_ovf);
    modport slave  (input  mode, in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_min, out_max, out_min_idx,
                           out_max_idx, out_count, out_ovf);
`endif

endinterface

`default_nettype wire

// File: rtl/fp_order_cmp.sv
// ============================================================================
// Module      : fp_order_cmp
// Description : Combinational three-way ordering of a against b, either as
//               raw unsigned bit patterns (mode 0) or signed IEEE order (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_order_cmp
    import fp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int MAN_WIDTH = MAN_WIDTH_DEF
) (
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic             mode_i,
    output logic      [1:0]       ord_o
);

    logic [EXP_WIDTH:0]   w_hi_a, w_hi_b;
    logic [MAN_WIDTH-1:0] w_man_a, w_man_b;
    logic                 w_raw_gt;
    logic                 w_mag_gt;

    assign w_hi_a  = a_i[WIDTH-1 -: EXP_WIDTH+1];
    assign w_hi_b  = b_i[WIDTH-1 -: EXP_WIDTH+1];
    assign w_man_a = a_i[MAN_WIDTH-1:0];
    assign w_man_b = b_i[MAN_WIDTH-1:0];

    // Sign+exponent decide first; the mantissa only breaks ties there
    assign w_raw_gt = (w_hi_a > w_hi_b) || ((w_hi_a == w_hi_b) && (w_man_a > w_man_b));
    assign w_mag_gt = a_i[WIDTH-2:0] > b_i[WIDTH-2:0];

    // Select the ordering code for the active mode
    always_comb begin
        ord_o = ORD_EQ;
        if (a_i == b_i) begin
            ord_o = ORD_EQ;
        end else if (!mode_i) begin
            ord_o = w_raw_gt ? ORD_GT : ORD_LT;
        end else if (a_i[WIDTH-1] != b_i[WIDTH-1]) begin
            // Covers +0 vs -0: the negative-signed operand orders below
            ord_o = a_i[WIDTH-1] ? ORD_LT : ORD_GT;
        end else if (!a_i[WIDTH-1]) begin
            ord_o = w_mag_gt ? ORD_GT : ORD_LT;
        end else begin
            ord_o = w_mag_gt ? ORD_LT : ORD_GT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_minmax_reduce.sv
// ============================================================================
// Module      : fp_minmax_reduce
// Description : Streaming running min/max reduction with element positions,
//               saturating count and held result handshake.
//               Optional macro FP_MINMAX_NAN_EN: NaNs are excluded from the
//               extremes and flagged on out_nan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_minmax_reduce
    import fp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int MAN_WIDTH = MAN_WIDTH_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fp_minmax_reduce_if.slave bus_io
);

    localparam logic [IDX_WIDTH-1:0] IDX_SAT = '1;
    localparam logic [IDX_WIDTH:0]   CNT_SAT = '1;
    localparam logic [IDX_WIDTH:0]   CNT_ONE = (IDX_WIDTH+1)'(1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     min_q, min_d, max_q, max_d;
    logic [IDX_WIDTH-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
    logic [IDX_WIDTH:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 mode_q, mode_d;
`ifdef FP_MINMAX_NAN_EN
    logic                 nan_q, nan_d;
    logic                 seeded_q, seeded_d;
    logic                 w_nan;
`endif

    logic                 w_accept;
    logic                 w_first;
    logic                 w_mode;
    logic [IDX_WIDTH-1:0] w_beat_idx;
    logic [1:0]           w_ord_min, w_ord_max;

    assign w_accept   = bus_io.in_valid & bus_io.in_ready;
    assign w_first    = (state_q == ST_IDLE);
    assign w_mode     = w_first ? bus_io.mode : mode_q;
    // count_q equals the zero-based index of the incoming beat; pin at all-ones past the end
    assign w_beat_idx = w_first ? '0 : (count_q[IDX_WIDTH] ? IDX_SAT : count_q[IDX_WIDTH-1:0]);
`ifdef FP_MINMAX_NAN_EN
    assign w_nan      = is_nan(bus_io.in_data[WIDTH-2 -: EXP_WIDTH], bus_io.in_data[MAN_WIDTH-1:0]);
`endif

    fp_order_cmp #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cmp_min (
        .a_i    (bus_io.in_data),
        .b_i    (min_q),
        .mode_i (w_mode),
        .ord_o  (w_ord_min)
    );

    fp_order_cmp #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cmp_max (
        .a_i    (bus_io.in_data),
        .b_i    (max_q),
        .mode_i (w_mode),
        .ord_o  (w_ord_max)
    );

    // Next state: accumulate until the last beat, then hold until accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: if (w_accept) state_d = bus_io.in_last ? ST_DONE : ST_ACCUM;
            ST_DONE:           if (bus_io.out_ready) state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Running extremes, positions, count and overflow for the accepted beat
    always_comb begin
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mode_d    = mode_q;
`ifdef FP_MINMAX_NAN_EN
        nan_d     = nan_q;
        seeded_d  = seeded_q;
`endif
        if (w_accept) begin
            count_d = w_first ? CNT_ONE : ((count_q == CNT_SAT) ? count_q : count_q + CNT_ONE);
            ovf_d   = w_first ? 1'b0 : (ovf_q | count_q[IDX_WIDTH]);
            if (w_first) mode_d = bus_io.mode;
`ifdef FP_MINMAX_NAN_EN
            nan_d = (w_first ? 1'b0 : nan_q) | w_nan;
            if (w_nan) begin
                // NaN never competes; a NaN-only prefix reports the canonical NaN
                if (w_first) begin
                    min_d     = WIDTH'(CANON_NAN);
                    max_d     = WIDTH'(CANON_NAN);
                    min_idx_d = '0;
                    max_idx_d = '0;
                    seeded_d  = 1'b0;
                end
            end else if (w_first || !seeded_q) begin
                min_d     = bus_io.in_data;
                max_d     = bus_io.in_data;
                min_idx_d = w_beat_idx;
                max_idx_d = w_beat_idx;
                seeded_d  = 1'b1;
            end else begin
                if (w_ord_min == ORD_LT) begin
                    min_d     = bus_io.in_data;
                    min_idx_d = w_beat_idx;
                end
                if (w_ord_max == ORD_GT) begin
                    max_d     = bus_io.in_data;
                    max_idx_d = w_beat_idx;
                end
            end
`else
            if (w_first) begin
                min_d     = bus_io.in_data;
                max_d     = bus_io.in_data;
                min_idx_d = '0;
                max_idx_d = '0;
            end else begin
                if (w_ord_min == ORD_LT) begin
                    min_d     = bus_io.in_data;
                    min_idx_d = w_beat_idx;
                end
                if (w_ord_max == ORD_GT) begin
                    max_d     = bus_io.in_data;
                    max_idx_d = w_beat_idx;
                end
            end
`endif
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            mode_q    <= 1'b0;
`ifdef FP_MINMAX_NAN_EN
            nan_q     <= 1'b0;
            seeded_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode_d;
`ifdef FP_MINMAX_NAN_EN
            nan_q     <= nan_d;
            seeded_q  <= seeded_d;
`endif
        end
    end

    assign bus_io.in_ready    = (state_q != ST_DONE);
    assign bus_io.out_valid   = (state_q == ST_DONE);
    assign bus_io.out_min     = min_q;
    assign bus_io.out_max     = max_q;
    assign bus_io.out_min_idx = min_idx_q;
    assign bus_io.out_max_idx = max_idx_q;
    assign bus_io.out_count   = count_q;
    assign bus_io.out_ovf     = ovf_q;
`ifdef FP_MINMAX_NAN_EN
    assign bus_io.out_nan     = nan_q;
`endif

endmodule

`default_nettype wire
